jk_bank_arbiter: RTL
====================

Name: jk_bank_arbiter

Overview:
- Shares one WIDTH-bit register, built from per-bit JK flip-flops, between NREQ requesters.
- A round-robin arbiter picks one request per cycle and translates its operation (load, set, clear, toggle) into J/K vectors.
- The J/K vectors are applied to the register on the following clock edge, and a one-cycle ack is returned to the winner.
- Sits beside the JK/D flip-flop primitives as the controller that sequences updates into a shared JK register.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register width in bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  request per requester; held high until that requester's ack is seen.
- op  input  2*NREQ  per-requester opcode, requester i at bits [2i+1:2i].
  - 00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE.
- data  input  WIDTH*NREQ  per-requester operand/mask, requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
- grant  output  NREQ  registered one-hot: requester whose operation is in stage 1.
- ack  output  NREQ  registered one-hot pulse: requester whose operation was applied to q at the last edge.
- q  output  WIDTH  shared JK register contents.

Behaviour:
- Reset (reset low, asynchronous): q=0, grant=0, ack=0, round-robin pointer ptr=0, stage-1 J/K registers=0.
  - Any in-flight operation is discarded, with no ack. Requesters must re-request after reset.
- Eligible set at each edge: elig = req & ~grant & ~ack.
  - A requester cannot be re-granted while its operation is in flight or while its ack is high.
- Stage 1 (arbitrate), at each rising edge:
  - Pick the first eligible index scanning ptr, ptr+1, … modulo NREQ.
  - If a winner w is found: grant<=onehot(w); J1/K1 registered from op[w]/data[w]; ptr<=(w+1) mod NREQ.
  - If nothing is eligible: grant<=0; J1=K1=0; ptr unchanged.
- Opcode to J/K mapping, with d = data of the winner:
  - LOAD: J=d, K=~d (D-flip-flop behaviour, q becomes d).
  - SET: J=d, K=0 (OR in the mask).
  - CLEAR: J=0, K=d (clear the masked bits).
  - TOGGLE: J=d, K=d (invert the masked bits).
- Stage 2 (apply), at the next rising edge:
  - Per bit: q <= (J1 & ~q) | (~K1 & q), i.e. JK characteristic with hold, set, reset and toggle.
  - ack<=grant; ack is high for exactly one cycle.
  - If grant was 0, q holds and ack<=0.
- Latency: req high before edge N → grant high after N → q updated and ack high after N+1.
- Throughput: one operation per cycle when requests come from different requesters.
  - A single requester holding req continuously is served at most every 3rd edge, because of the grant/ack mask.
- Ack dropout: req dropping before ack abandons nothing. A granted operation always completes.
- Invariants: grant and ack are each zero or one-hot; grant & ack == 0 is not required.
  - With NREQ=1, the single requester alternates grant/ack/idle.
- Operation ops/data are sampled only at the grant edge. Later changes do not affect an in-flight operation.

Test Plan:
- Reset, then idle: q=0, grant=0, ack=0 for 5 cycles. Assert reset mid-transaction (grant high) → ack never pulses, q=0.
- Req0 LOAD data=8'hA5 → grant=0001 after edge N, q=A5 and ack=0001 after N+1. Then req0 SET 8'h0F → q=AF.
- Starting from q=AF: CLEAR 8'hF0 → q=0F. Then TOGGLE 8'hFF → q=F0.
- All four requesters request simultaneously from reset, ptr=0 → grants 0,1,2,3 on consecutive edges. Acks follow one cycle later. Final q equals the sequential application of the four ops.
- Req1 and req3 held continuously with ptr=2 → grant order 3,1,3,1… subject to the grant/ack mask. No requester is granted while its grant or ack is high.
- Req2 changes op/data the cycle after its grant → q reflects the values sampled at the grant edge.

Source files
------------

// File: rtl/jk_bank_arbiter_if.sv
// Bus between the requesters and the shared JK register arbiter.
// The master side drives requests, opcodes and operands. The slave side
// returns grant, ack and the register contents.
interface jk_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] data;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;

  modport master (output req, op, data, input grant, ack, q);
  modport slave  (input req, op, data, output grant, ack, q);
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that sequences requester operations into one shared
// register built from per-bit JK flip-flops.
//   Stage 1 picks a winner and registers its J/K vectors.
//   Stage 2 applies J/K to the register and pulses ack to that winner.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  jk_bank_arbiter_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  ack_q;
  logic [WIDTH-1:0] j1_q, j1_d;
  logic [WIDTH-1:0] k1_q, k1_d;
  logic [WIDTH-1:0] q_q;
  logic [NREQ-1:0]  elig;
  logic             found;
  int               win;
  int               idx;
  int               nxt;
  logic [WIDTH-1:0] win_data;
  op_e              win_op;

  // Stage 1 combinational part: pick the first eligible requester from ptr
  // onward and translate its opcode into J/K vectors.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    elig     = bus.req & ~grant_q & ~ack_q;
    found    = 1'b0;
    win      = 0;
    idx      = 0;
    nxt      = 0;
    grant_d  = '0;
    j1_d     = '0;
    k1_d     = '0;
    ptr_d    = ptr_q;
    win_data = '0;
    win_op   = OP_LOAD;

    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    if (found) begin
      win_data     = bus.data[WIDTH*win +: WIDTH];
      win_op       = op_e'(bus.op[2*win +: 2]);
      grant_d[win] = 1'b1;
      nxt          = win + 1;
      ptr_d        = (nxt >= NREQ) ? '0 : PTR_W'(nxt);
      unique case (win_op)
        OP_LOAD:   begin j1_d = win_data; k1_d = ~win_data; end
        OP_SET:    begin j1_d = win_data; k1_d = '0;        end
        OP_CLEAR:  begin j1_d = '0;       k1_d = win_data;  end
        OP_TOGGLE: begin j1_d = win_data; k1_d = win_data;  end
      endcase
    end
  end

  // Pipeline registers: stage-1 arbitration state and stage-2 JK register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      j1_q    <= '0;
      k1_q    <= '0;
      q_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, so stage 2 uses last cycle's J/K and grant.
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      j1_q    <= j1_d;
      k1_q    <= k1_d;
      ack_q   <= grant_q;
      q_q     <= (j1_q & ~q_q) | (~k1_q & q_q);
    end
  end

  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;
  assign bus.q     = q_q;

endmodule
